mul_iter_ctrl: RTL and testbench
================================

# mul_iter_ctrl

Iterative radix-4 Booth multiplier sequencer for the execute unit. It accepts one RV64M multiply request at a time and accumulates one Booth partial product per cycle into a carry-save pair through a row of 3:2 compressors. It then resolves the pair with one carry-propagate add and holds the result until the writeback side accepts it. It sits between issue and the EXU result bus, next to the other multiplier components.

## Interface
- XLEN, 64, operand/result width; must be even and ≥ 32
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request this cycle
- req_op  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 MULW; 5–7 are executed as MUL
- req_src1  input  XLEN  multiplicand (rs1)
- req_src2  input  XLEN  multiplier (rs2)
- flush  input  1  synchronous kill of any in-flight operation
- resp_valid  output  1  result available
- resp_ready  input  1  consumer accepts result
- resp_data  output  XLEN  result
- busy  output  1  high in any state other than IDLE

## Operation
- Four states: IDLE, CALC, ADD, DONE.
- IDLE:
  - req_ready = !flush.
  - A handshake (req_valid & req_ready) latches op and operands, clears the sum/carry accumulators, and loads the iteration counter.
  - Next state is CALC.
- Operand extension:
  - src1 is sign-extended for MUL, MULH, MULHSU and MULW; zero-extended for MULHU.
  - src2 is sign-extended for MUL, MULH and MULW; zero-extended for MULHSU and MULHU.
  - Both operands extend to XLEN+2 bits.
  - MULW first replaces each operand with the sign-extension of its low 32 bits.
- CALC:
  - Each cycle recodes 3 multiplier bits (overlapping, with an implicit 0 below bit 0) to one of {0, +M, −M, +2M, −2M}.
  - −M / −2M are formed as bitwise inverse, with the +1 injected at the partial product's LSB position in the carry vector.
  - The partial product is aligned at bit 2·i and compressed with the current sum/carry (3:2 row, carry shifted left 1).
  - Accumulator width is 2·XLEN+4 bits, truncated modulo 2^(2·XLEN+4).
  - Iteration count is XLEN/2+1 (33 for XLEN=64); for MULW it is 17.
  - CALC moves to ADD after the last iteration.
- ADD: one cycle. product = sum + carry, then the result is selected:
  - MUL: product[XLEN-1:0]
  - MULH, MULHSU, MULHU: product[2·XLEN-1:XLEN]
  - MULW: sign-extension of product[31:0]
  - resp_data is registered and the state moves to DONE.
- DONE:
  - resp_valid = 1 and resp_data is held stable until resp_ready.
  - On the handshake, the next state is IDLE. A new request is not accepted in the same cycle.
- flush: in any state, the next state is IDLE and resp_valid drops next cycle. A request presented with flush high is not accepted. A DONE result that is flushed is lost even if resp_ready is high in that cycle; flush has priority.
- Reset: state IDLE, resp_valid 0, resp_data 0, busy 0, counter 0, accumulators 0. req_ready is 1 out of reset when flush is low. Reset assertion mid-operation aborts immediately with no response.

## Timing
- Request handshake at edge t. CALC occupies cycles t+1 … t+N (N = 33, or 17 for MULW), ADD occupies t+N+1, and resp_valid rises at t+N+2.
- Latency from request to response is 35 cycles (MUL/MULH/MULHSU/MULHU, XLEN=64) or 19 cycles (MULW) when resp_ready is held high.
- Throughput is one operation per N+3 cycles at best, because of the IDLE turnaround.
- req_ready and busy are derived combinationally from the state register plus flush; there is no input→output combinational path other than flush→req_ready.
- resp_data and resp_valid come directly from registers.

## Structure
- Shared package mul_pkg holds:
  - the mul_op_e encoding (MUL=0 … MULW=4)
  - the mul_state_e enum
  - the Booth select encoding
  - MUL_ITER = XLEN/2+1 and MULW_ITER = 17
- Sub-module csa_row (parameter W): W instances of compressor_3to2 forming one carry-save row; mul_iter_ctrl instantiates it once.
- The Booth recoder and partial-product mux stay inline.

## Test plan
- MUL: src1=3, src2=0xFFFF_FFFF_FFFF_FFFB (−5) → resp_data=0xFFFF_FFFF_FFFF_FFF1, resp_valid exactly 35 cycles after handshake.
- MULH: 0x8000_0000_0000_0000 × itself → 0x4000_0000_0000_0000. MULH −1×−1 → 0.
- MULHU: all-ones × all-ones → 0xFFFF_FFFF_FFFF_FFFE. MULHSU: src1=−1, src2=0x8000_0000_0000_0000 → 0xFFFF_FFFF_FFFF_FFFF.
- MULW: src1=0x7FFF_FFFF, src2=2 → 0xFFFF_FFFF_FFFF_FFFE after 19 cycles. Upper operand bits set to garbage do not change the result.
- Backpressure: resp_ready low for 10 cycles in DONE → resp_data stable and req_ready low throughout. Releasing resp_ready → IDLE next cycle, and the next request is accepted.
- Flush in CALC cycle 5 with req_valid high → IDLE next cycle, no resp_valid, that request not accepted. rst_n pulsed low mid-CALC → all outputs at reset values immediately.

Source files
------------

// File: rtl/mul_pkg.sv
// mul_pkg: shared encodings and iteration counts for the iterative Booth multiplier
package mul_pkg;
  localparam int DEF_XLEN = 64;
  localparam int MUL_ITER = DEF_XLEN / 2 + 1;
  localparam int MULW_ITER = 17;
  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_MULW   = 3'd4
  } mul_op_e;
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_ADD, S_DONE} mul_state_e;
  typedef enum logic [2:0] {B_ZERO, B_POS1, B_POS2, B_NEG1, B_NEG2} booth_sel_e;
  function automatic booth_sel_e booth_enc(input logic [2:0] g);
    case (g)
      3'b001, 3'b010: return B_POS1;
      3'b011:         return B_POS2;
      3'b100:         return B_NEG2;
      3'b101, 3'b110: return B_NEG1;
      default:        return B_ZERO;
    endcase
  endfunction
endpackage

// File: rtl/compressor_3to2.sv
// compressor_3to2: single-bit full adder used as a 3:2 carry-save compressor
module compressor_3to2 (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

// File: rtl/csa_row.sv
// csa_row: W-bit carry-save row; carry output is unshifted, caller aligns it
module csa_row #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] c_i,
  output logic [W-1:0] s_o,
  output logic [W-1:0] c_o
);
  for (genvar g = 0; g < W; g++) begin : g_bit
    compressor_3to2 u_fa (.a_i(a_i[g]), .b_i(b_i[g]), .c_i(c_i[g]), .s_o(s_o[g]), .c_o(c_o[g]));
  end
endmodule

// File: rtl/mul_iter_ctrl.sv
// mul_iter_ctrl: iterative radix-4 Booth multiplier sequencer for RV64M multiplies
module mul_iter_ctrl
  import mul_pkg::*;
#(
  parameter int XLEN = DEF_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_src1,
  input  logic [XLEN-1:0] req_src2,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            busy
);
  localparam int AW = 2 * XLEN + 4;
  localparam int EW = XLEN + 2;
  localparam int NITER = XLEN / 2 + 1;
  localparam int CW = $clog2(NITER + 1);
  mul_state_e state_q;
  mul_op_e op_q, op_d;
  logic [AW-1:0] sum_q, carry_q, mcand_q, lsb_q;
  logic [EW:0] mplr_q;
  logic neg_q;
  logic [CW-1:0] cnt_q;
  logic resp_valid_q;
  logic [XLEN-1:0] resp_data_q, res_d, a_w, b_w;
  logic a_sgn, b_sgn;
  logic [EW-1:0] a_ext, b_ext;
  booth_sel_e sel;
  logic [AW-1:0] hi_mask, pp, inj, csa_s, csa_c;
  logic [2*XLEN-1:0] prod;
  assign req_ready = (state_q == S_IDLE) & ~flush;
  assign busy = state_q != S_IDLE;
  assign resp_valid = resp_valid_q;
  assign resp_data = resp_data_q;
  assign op_d = req_op > 3'd4 ? OP_MUL : mul_op_e'(req_op);
  assign a_w = op_d == OP_MULW ? {{(XLEN-32){req_src1[31]}}, req_src1[31:0]} : req_src1;
  assign b_w = op_d == OP_MULW ? {{(XLEN-32){req_src2[31]}}, req_src2[31:0]} : req_src2;
  assign a_sgn = (op_d != OP_MULHU) & a_w[XLEN-1];
  assign b_sgn = (op_d != OP_MULHSU) & (op_d != OP_MULHU) & b_w[XLEN-1];
  assign a_ext = {{2{a_sgn}}, a_w};
  assign b_ext = {{2{b_sgn}}, b_w};
  assign sel = booth_enc(mplr_q[2:0]);
  assign hi_mask = ~(lsb_q - AW'(1));
  assign pp = sel == B_POS1 ? mcand_q :
              sel == B_POS2 ? mcand_q << 1 :
              sel == B_NEG1 ? ~mcand_q & hi_mask :
              sel == B_NEG2 ? ~(mcand_q << 1) & hi_mask : '0;
  // The +1 of a negated row lands in the next row's free low bits, which are
  // always zero there; the final row never negates because of the 2-bit extension.
  assign inj = neg_q ? lsb_q >> 2 : '0;
  csa_row #(.W(AW)) u_row (.a_i(sum_q), .b_i(carry_q), .c_i(pp | inj), .s_o(csa_s), .c_o(csa_c));
  assign prod = sum_q[2*XLEN-1:0] + carry_q[2*XLEN-1:0];
  assign res_d = op_q == OP_MUL  ? prod[XLEN-1:0] :
                 op_q == OP_MULW ? {{(XLEN-32){prod[31]}}, prod[31:0]} : prod[2*XLEN-1:XLEN];
  // Sequencer: latch request, accumulate one Booth row per cycle, resolve, hold result
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q <= OP_MUL;
      sum_q <= '0;
      carry_q <= '0;
      mcand_q <= '0;
      lsb_q <= '0;
      mplr_q <= '0;
      neg_q <= 1'b0;
      cnt_q <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q <= '0;
    end else if (flush) begin
      state_q <= S_IDLE;
      resp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (req_valid) begin
          op_q <= op_d;
          sum_q <= '0;
          carry_q <= '0;
          mcand_q <= {{(AW-EW){a_ext[EW-1]}}, a_ext};
          lsb_q <= AW'(1);
          mplr_q <= {b_ext, 1'b0};
          neg_q <= 1'b0;
          cnt_q <= op_d == OP_MULW ? CW'(MULW_ITER) : CW'(NITER);
          state_q <= S_CALC;
        end
        S_CALC: begin
          sum_q <= csa_s;
          carry_q <= csa_c << 1;
          neg_q <= (sel == B_NEG1) | (sel == B_NEG2);
          mcand_q <= mcand_q << 2;
          lsb_q <= lsb_q << 2;
          mplr_q <= {{2{mplr_q[EW]}}, mplr_q[EW:2]};
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= S_ADD;
        end
        S_ADD: begin
          resp_data_q <= res_d;
          resp_valid_q <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: if (resp_ready) begin
          resp_valid_q <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_mul_iter_ctrl.sv
// tb_mul_iter_ctrl: directed and random checks of mul_iter_ctrl against a 128-bit arithmetic model
module tb_mul_iter_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 1'b0;
  logic flush = 1'b0;
  logic resp_ready = 1'b0;
  logic [2:0] req_op = 3'd0;
  logic [63:0] req_src1 = '0;
  logic [63:0] req_src2 = '0;
  logic req_ready, resp_valid, busy;
  logic [63:0] resp_data;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  mul_iter_ctrl #(.XLEN(64)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op(req_op),
    .req_src1(req_src1),
    .req_src2(req_src2),
    .flush(flush),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data(resp_data),
    .busy(busy)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] ref_mul(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p;
    logic [63:0] w;
    case (op)
      3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
      3'd2: begin p = {{64{a[63]}}, a} * {64'd0, b}; return p[127:64]; end
      3'd3: begin p = {64'd0, a} * {64'd0, b}; return p[127:64]; end
      3'd4: begin w = {32'd0, a[31:0]} * {32'd0, b[31:0]}; return {{32{w[31]}}, w[31:0]}; end
      default: return a * b;
    endcase
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    int k;
    req_op = op;
    req_src1 = a;
    req_src2 = b;
    req_valid = 1'b1;
    #1;
    k = 0;
    while (!req_ready && k < 50) begin
      tick;
      k++;
    end
    chk("req_ready_before_issue", 64'(req_ready), 64'd1);
    tick;
    req_valid = 1'b0;
    req_src1 = {$urandom, $urandom};
    req_src2 = {$urandom, $urandom};
    req_op = 3'($urandom_range(0, 7));
    chk("busy_after_issue", 64'(busy), 64'd1);
  endtask
  task automatic run_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input int hold);
    int lat;
    logic [63:0] held;
    resp_ready = (hold == 0);
    issue(op, a, b);
    lat = 1;
    while (!resp_valid && lat < 100) begin
      tick;
      lat++;
    end
    chk("latency", 64'(lat), op == 3'd4 ? 64'd19 : 64'd35);
    chk("resp_data", resp_data, exp);
    held = resp_data;
    for (int i = 0; i < hold; i++) begin
      tick;
      chk("hold_valid", 64'(resp_valid), 64'd1);
      chk("hold_data", resp_data, held);
      chk("hold_req_ready", 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    tick;
    resp_ready = 1'b0;
    chk("idle_valid", 64'(resp_valid), 64'd0);
    chk("idle_req_ready", 64'(req_ready), 64'd1);
    chk("idle_busy", 64'(busy), 64'd0);
  endtask
  initial begin
    logic [2:0] op;
    logic [63:0] a, b;
    int seen;
    #1;
    chk("rst_valid", 64'(resp_valid), 64'd0);
    chk("rst_data", resp_data, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    tick;
    rst_n = 1'b1;
    tick;
    run_op(3'd0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 0);
    run_op(3'd1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, 0);
    run_op(3'd1, '1, '1, 64'd0, 0);
    run_op(3'd3, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 0);
    run_op(3'd2, '1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    run_op(3'd4, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 0);
    run_op(3'd4, 64'hDEAD_BEEF_7FFF_FFFF, 64'h1234_5678_0000_0002, 64'hFFFF_FFFF_FFFF_FFFE, 0);
    run_op(3'd6, 64'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF9, 0);
    run_op(3'd0, 64'd123456789, 64'd987654321, 64'd121932631112635269, 10);
    // flush in the fifth CALC cycle while a new request is offered
    resp_ready = 1'b1;
    issue(3'd0, 64'd5, 64'd6);
    repeat (4) tick;
    req_valid = 1'b1;
    flush = 1'b1;
    #1;
    chk("flush_req_ready", 64'(req_ready), 64'd0);
    tick;
    flush = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_valid", 64'(resp_valid), 64'd0);
    chk("flush_req_ready_after", 64'(req_ready), 64'd1);
    seen = 0;
    repeat (40) begin
      tick;
      if (resp_valid || busy) seen++;
    end
    chk("flush_no_resp", 64'(seen), 64'd0);
    // flush wins over resp_ready in DONE
    resp_ready = 1'b0;
    issue(3'd0, 64'd9, 64'd9);
    seen = 0;
    while (!resp_valid && seen < 100) begin
      tick;
      seen++;
    end
    chk("done_reached", 64'(resp_valid), 64'd1);
    flush = 1'b1;
    resp_ready = 1'b1;
    tick;
    flush = 1'b0;
    resp_ready = 1'b0;
    chk("done_flush_valid", 64'(resp_valid), 64'd0);
    chk("done_flush_busy", 64'(busy), 64'd0);
    // asynchronous reset mid-CALC
    issue(3'd1, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321);
    repeat (10) tick;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(resp_valid), 64'd0);
    chk("arst_data", resp_data, 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_req_ready", 64'(req_ready), 64'd1);
    tick;
    tick;
    rst_n = 1'b1;
    tick;
    for (int n = 0; n < 24; n++) begin
      op = 3'($urandom_range(0, 7));
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if ($urandom_range(0, 5) == 0) a = $urandom_range(0, 1) ? '1 : 64'h8000_0000_0000_0000;
      if ($urandom_range(0, 5) == 0) b = $urandom_range(0, 1) ? 64'd0 : '1;
      run_op(op, a, b, ref_mul(op, a, b), $urandom_range(0, 3));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
